// File: rtl/bias_ctrl.sv
// bias_ctrl: loads one bias scalar per column, then counts per-column systolic valids to completion.
module bias_ctrl #(
   parameter int DATA_W = 16,
   parameter int ROW_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ROW_W-1:0]  cfg_rows,
   output logic              busy,
   output logic              done,
   input  logic              bias_load_valid,
   input  logic [DATA_W-1:0] bias_load_data,
   output logic              bias_load_ready,
   input  logic              bias_sys_valid_in_1,
   input  logic              bias_sys_valid_in_2,
   output logic [DATA_W-1:0] bias_scalar_out_1,
   output logic [DATA_W-1:0] bias_scalar_out_2,
   output logic              err_stray
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [ROW_W-1:0] rows_q, rows_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d, sum1, sum2;
   logic [DATA_W-1:0] s1_q, s1_d, s2_q, s2_d;
   logic idx_q, idx_d, err_q, err_d, inc1, inc2;
   logic busy_q, done_q, ready_q;
   // counters saturate at rows_q; any valid that cannot be counted is stray
   assign inc1 = state_q == RUN && bias_sys_valid_in_1 && cnt1_q != rows_q;
   assign inc2 = state_q == RUN && bias_sys_valid_in_2 && cnt2_q != rows_q;
   assign sum1 = cnt1_q + ROW_W'(inc1);
   assign sum2 = cnt2_q + ROW_W'(inc2);
   assign err_d = err_q | (bias_sys_valid_in_1 & ~inc1) | (bias_sys_valid_in_2 & ~inc2);
   always_comb begin
      state_d = state_q;
      rows_d  = rows_q;
      cnt1_d  = cnt1_q;
      cnt2_d  = cnt2_q;
      idx_d   = idx_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            rows_d  = cfg_rows;
            cnt1_d  = '0;
            cnt2_d  = '0;
            idx_d   = 1'b0;
         end
         LOAD: if (bias_load_valid) begin
            if (!idx_q) begin
               s1_d  = bias_load_data;
               idx_d = 1'b1;
            end else begin
               s2_d    = bias_load_data;
               state_d = rows_q == '0 ? DONE : RUN;
            end
         end
         RUN: begin
            cnt1_d  = sum1;
            cnt2_d  = sum2;
            state_d = (sum1 == rows_q && sum2 == rows_q) ? DONE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rows_q  <= '0;
         cnt1_q  <= '0;
         cnt2_q  <= '0;
         idx_q   <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rows_q  <= rows_d;
         cnt1_q  <= cnt1_d;
         cnt2_q  <= cnt2_d;
         idx_q   <= idx_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         err_q   <= err_d;
         busy_q  <= state_d != IDLE;
         done_q  <= state_d == DONE;
         ready_q <= state_d == LOAD;
      end
   end
   assign busy              = busy_q;
   assign done              = done_q;
   assign bias_load_ready   = ready_q;
   assign bias_scalar_out_1 = s1_q;
   assign bias_scalar_out_2 = s2_q;
   assign err_stray         = err_q;
endmodule

// File: tb/tb_bias_ctrl.sv
// tb_bias_ctrl: directed test-plan layers plus random traffic against a transaction-level model.
module tb_bias_ctrl;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, lv = 1'b0, v1 = 1'b0, v2 = 1'b0;
   logic [7:0] cfg = '0;
   logic [15:0] ld = '0;
   logic busy, done, ready, err;
   logic [15:0] so1, so2;
   int passed = 0, total = 0;

   bias_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg), .busy(busy), .done(done),
      .bias_load_valid(lv), .bias_load_data(ld), .bias_load_ready(ready),
      .bias_sys_valid_in_1(v1), .bias_sys_valid_in_2(v2),
      .bias_scalar_out_1(so1), .bias_scalar_out_2(so2), .err_stray(err)
   );

   always #5 clk = ~clk;

   // model: a layer is "on" from start until its done cycle ends; words loaded, rows seen per column
   bit m_on, m_fin, m_err;
   int m_loaded, m_rows;
   int m_got[2];
   logic [15:0] m_sc[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model(input bit st, input int c, input bit l, input logic [15:0] d,
                        input bit a, input bit b, input bit r);
      bit counting;
      bit vv[2];
      bit cnt[2];
      vv[0] = a; vv[1] = b;
      if (r) begin
         m_on = 0; m_fin = 0; m_err = 0; m_loaded = 0; m_rows = 0;
         m_got[0] = 0; m_got[1] = 0; m_sc[0] = '0; m_sc[1] = '0;
         return;
      end
      counting = m_on && m_loaded == 2 && !m_fin;
      for (int i = 0; i < 2; i++) begin
         cnt[i] = counting && vv[i] && m_got[i] < m_rows;
         if (vv[i] && !cnt[i]) m_err = 1;
      end
      if (m_fin) begin
         m_on = 0; m_fin = 0;
      end else if (!m_on) begin
         if (st) begin
            m_on = 1; m_rows = c; m_loaded = 0; m_got[0] = 0; m_got[1] = 0;
         end
      end else if (m_loaded < 2) begin
         if (l) begin
            m_sc[m_loaded] = d;
            m_loaded++;
            if (m_loaded == 2 && m_rows == 0) m_fin = 1;
         end
      end else begin
         for (int i = 0; i < 2; i++) m_got[i] += int'(cnt[i]);
         if (m_got[0] == m_rows && m_got[1] == m_rows) m_fin = 1;
      end
   endtask

   task automatic cyc(input bit st, input int c, input bit l, input logic [15:0] d,
                      input bit a, input bit b, input bit r);
      start = st; cfg = 8'(c); lv = l; ld = d; v1 = a; v2 = b; rst = r;
      model(st, c, l, d, a, b, r);
      @(posedge clk);
      #1;
      chk("busy", 32'(busy), 32'(m_on));
      chk("done", 32'(done), 32'(m_fin));
      chk("ready", 32'(ready), 32'(m_on && m_loaded < 2));
      chk("scalar1", 32'(so1), 32'(m_sc[0]));
      chk("scalar2", 32'(so2), 32'(m_sc[1]));
      chk("err_stray", 32'(err), 32'(m_err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0, 0, 0, 0);
   endtask

   task automatic load2(input logic [15:0] a, input logic [15:0] b);
      cyc(0, 0, 1, a, 0, 0, 0);
      cyc(0, 0, 1, b, 0, 0, 0);
   endtask

   initial begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      idle(1);
      // nominal: rows=4, column 2 lags by one cycle
      cyc(1, 4, 0, 0, 0, 0, 0);
      load2(16'h0100, 16'hFF80);
      cyc(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("nominal_done", 32'(done), 32'd1);
      idle(2);
      chk("nominal_idle", 32'(busy), 32'd0);
      // gapped load handshakes
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 16'h1234, 0, 0, 0);
      cyc(0, 0, 0, 16'hDEAD, 0, 0, 0);
      cyc(0, 0, 0, 16'hBEEF, 0, 0, 0);
      chk("bp_hold", 32'(so2), 32'hFF80);
      cyc(0, 0, 1, 16'h5678, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 0);
      idle(2);
      // rows=0 goes straight from LOAD to DONE
      cyc(1, 0, 0, 0, 0, 0, 0);
      load2(16'h0001, 16'h0002);
      chk("rows0_done", 32'(done), 32'd1);
      idle(2);
      chk("rows0_err", 32'(err), 32'd0);
      // stray in IDLE, then overflow valid on column 2
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("stray_idle", 32'(err), 32'd1);
      cyc(1, 2, 0, 0, 0, 0, 0);
      load2(16'h0A0A, 16'h0B0B);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      idle(2);
      // reset mid-RUN, then a normal rows=1 layer
      cyc(1, 4, 0, 0, 0, 0, 0);
      load2(16'h7FFF, 16'h8000);
      cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("rst_scalar", 32'(so1), 32'd0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      load2(16'h0011, 16'h0022);
      cyc(0, 0, 0, 0, 1, 1, 0);
      idle(2);
      // start during RUN must not resample cfg_rows
      cyc(1, 3, 0, 0, 0, 0, 0);
      load2(16'h0033, 16'h0044);
      for (int i = 0; i < 3; i++) cyc(1, 9, 0, 0, 1, 1, 0);
      chk("busy_start_done", 32'(done), 32'd1);
      idle(2);
      // random traffic
      for (int i = 0; i < 2000; i++)
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5), $urandom_range(0, 1) == 1,
             16'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 99) == 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/bias_ctrl.md
# bias_ctrl

Sequencer for the two-column bias stage. Per layer it loads one signed 16-bit bias scalar per column through a valid/ready handshake and holds it on the column scalar inputs. It then counts the valid results arriving from the systolic array on each column and signals completion once both columns have seen the configured number of rows. It sits between the top-level layer controller and the bias stage; per-column counting absorbs the array's column skew.

## Interface
Parameters:
- DATA_W, 16, bias scalar width (signed)
- ROW_W, 8, width of the row count and of the row counters

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer; accepted only in IDLE
- cfg_rows  in  ROW_W  rows per column for this layer; sampled when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion of a layer
- bias_load_valid  in  1  bias word offered
- bias_load_data  in  DATA_W  bias word; first word goes to column 1, second to column 2
- bias_load_ready  out  1  high only in LOAD
- bias_sys_valid_in_1  in  1  column 1 systolic result valid, observed by this block
- bias_sys_valid_in_2  in  1  column 2 systolic result valid, observed by this block
- bias_scalar_out_1  out  DATA_W  drives column 1 bias scalar
- bias_scalar_out_2  out  DATA_W  drives column 2 bias scalar
- err_stray  out  1  sticky; a column valid arrived outside RUN or beyond cfg_rows; cleared only by rst

## Operation
- **States:**
  - IDLE: start → LOAD, latch cfg_rows into rows_q, clear both counters and load_idx.
  - LOAD: bias_load_ready=1. Each cycle with valid&ready captures bias_load_data.
    - load_idx 0 → scalar_1, then load_idx becomes 1.
    - load_idx 1 → scalar_2, then next state is RUN, or DONE directly if rows_q==0.
  - RUN: cnt_1 increments on bias_sys_valid_in_1 while cnt_1<rows_q; cnt_2 likewise. When both counters equal rows_q (using the post-increment value, so the last valid pulse counts), next state is DONE.
  - DONE: done=1 for exactly this cycle, then → IDLE.
- **Scalar hold:** scalar_1/scalar_2 hold their values after DONE and through IDLE until overwritten in the next LOAD. This keeps the bias stage's in-flight tail correct.
- **Counter width:** counters are ROW_W bits and never wrap, since they saturate at rows_q.
- **err_stray sets on any of these:**
  - a column valid in IDLE, LOAD or DONE;
  - a column valid in RUN while that column's counter already equals rows_q.

  The offending valid is not counted.
- **Busy start:** start while busy is ignored and does not resample cfg_rows.
- **Independent columns:** each column's valid is counted on its own. A 1-cycle column 2 lag, or any skew, is allowed.

## Timing
- **Reset values:** busy=0, done=0, bias_load_ready=0, bias_scalar_out_1/2=0, err_stray=0. State IDLE, counters 0, load_idx 0.
- **rst mid-operation:** rst in any state returns to IDLE on the next edge. Partially loaded scalars are zeroed and no done pulse is produced.
- **Cycle-by-cycle:**
  - start high at edge k → busy=1 and bias_load_ready=1 from cycle k+1.
  - A handshake at edge j updates the scalar output at j+1.
  - The second handshake at edge m → RUN from m+1, and bias_load_ready=0 from m+1.
  - Final counting valid at edge n → DONE in cycle n+1 (done=1, busy=1) → IDLE in n+2 (busy=0).
- **Minimum layer time:** with back-to-back loads and rows=R, the layer takes 1 + 2 + (R with skew) + 1 cycles. With rows=0: start, 2 load cycles, DONE, IDLE.
- **Column valid in the load cycle:** a column valid in the same cycle as the second load handshake is not counted and sets err_stray.
- **All outputs are registered.**

## Test plan
- **Nominal:**
  - Stimulus: rows=4, load 0x0100 then 0xFF80 back-to-back. Column 1 valid on cycles 0-3 of RUN; column 2 valid on cycles 1-4.
  - Required: scalar_1=0x0100, scalar_2=0xFF80; done pulses exactly once, the cycle after column 2's 4th valid; busy falls the cycle after that.
- **Load backpressure:**
  - Stimulus: bias_load_valid gapped (valid on cycles 0, 3).
  - Required: ready held high throughout; scalars capture only on valid cycles; RUN entered the cycle after cycle 3.
- **rows=0:**
  - Stimulus: start with cfg_rows=0, two load words.
  - Required: state goes LOAD→DONE with no RUN cycle; done one cycle; err_stray stays 0.
- **Stray and overflow valids:**
  - Stimulus: a column 1 valid in IDLE; separately, with rows=2, a third column 2 valid in RUN.
  - Required: err_stray=1 and sticky; counters not incremented past 2; done timing unchanged.
- **Reset mid-RUN:**
  - Stimulus: rst high after 2 of 4 rows.
  - Required: next cycle busy=0, scalars=0, no done. A subsequent start with rows=1 completes normally.
- **Busy start:**
  - Stimulus: start pulsed with cfg_rows=9 during RUN of a rows=3 layer.
  - Required: ignored; done after 3 rows per column.
